// File: rtl/scale_pixel_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : pkg_scalePixelScheduler                                     |
// | Shared types and defaults for the scale pixel scheduler: FSM state    |
// | encoding, default widths/drain length and the latched job config.     |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package pkg_scalePixelScheduler;

  localparam int unsigned C_FIXED        = 16;
  localparam int unsigned C_COORD_W      = 12;
  localparam int unsigned C_DRAIN_CYCLES = 16;

  typedef enum logic [1:0] {
    S_Idle  = 2'd0,
    S_Issue = 2'd1,
    S_Drain = 2'd2
  } STATES_t;

  // Job configuration captured at the config handshake (default widths).
  typedef struct packed {
    logic [C_COORD_W-1:0]         src_w;
    logic [C_COORD_W-1:0]         src_h;
    logic [C_COORD_W-1:0]         dst_w;
    logic [C_COORD_W-1:0]         dst_h;
    logic [C_COORD_W+C_FIXED-1:0] step_x;
    logic [C_COORD_W+C_FIXED-1:0] step_y;
  } CFG_t;

endpackage
`default_nettype wire

// File: rtl/scale_pixel_scheduler_axis.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scale_axis_accumulator                                      |
// | One axis of the scheduler: destination index counter, saturating     |
// | fixed-point source accumulator and clamp of the 2x2 neighbourhood to  |
// | the source edge. Integer/fraction outputs are registered.             |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module scale_axis_accumulator #(
  parameter int unsigned FIXED   = 16,
  parameter int unsigned COORD_W = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,     // new job: index and accumulator to 0
  input  logic                     advance,   // step to the next destination index
  input  logic                     wrap,      // return to index 0 / position 0
  input  logic [COORD_W+FIXED-1:0] step,
  input  logic [COORD_W-1:0]       src,       // source size the clamp applies to
  input  logic [COORD_W-1:0]       last_idx,  // destination size minus one
  output logic [COORD_W-1:0]       idx,
  output logic                     is_last,
  output logic [COORD_W-1:0]       pos_int,
  output logic [FIXED-1:0]         pos_frac
);

  localparam int unsigned C_ACC_W = COORD_W + FIXED;

  logic [C_ACC_W-1:0] r_acc;
  logic [C_ACC_W-1:0] w_acc_next;
  logic [C_ACC_W:0]   w_sum;
  logic [COORD_W-1:0] r_idx;
  logic [COORD_W-1:0] w_idx_next;
  logic [COORD_W-1:0] w_src_lim;
  logic [COORD_W-1:0] w_int_next;
  logic [COORD_W-1:0] r_int;
  logic [FIXED-1:0]   w_frac_next;
  logic [FIXED-1:0]   r_frac;

  // One extra bit of headroom so overflow is seen and saturated instead of wrapped.
  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, step};
  end

  // Next index/accumulator value for this cycle.
  always_comb begin
    w_acc_next = r_acc;
    w_idx_next = r_idx;
    if (clear || wrap) begin
      w_acc_next = '0;
      w_idx_next = '0;
    end else if (advance) begin
      w_acc_next = w_sum[C_ACC_W] ? {C_ACC_W{1'b1}} : w_sum[C_ACC_W-1:0];
      w_idx_next = r_idx + 1'b1;
    end
  end

  // Clamp so the 2x2 neighbourhood (sx, sx+1) stays inside the source image.
  always_comb begin
    w_src_lim   = src - COORD_W'(2);
    w_int_next  = w_acc_next[C_ACC_W-1:FIXED];
    w_frac_next = w_acc_next[FIXED-1:0];
    if (w_acc_next[C_ACC_W-1:FIXED] > w_src_lim) begin
      w_int_next  = w_src_lim;
      w_frac_next = {FIXED{1'b1}};
    end
  end

  // Register position state and the clamped source sample together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc  <= '0;
      r_idx  <= '0;
      r_int  <= '0;
      r_frac <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_idx  <= w_idx_next;
      r_int  <= w_int_next;
      r_frac <= w_frac_next;
    end
  end

  assign idx      = r_idx;
  assign is_last  = (r_idx == last_idx);
  assign pos_int  = r_int;
  assign pos_frac = r_frac;

endmodule
`default_nettype wire

// File: rtl/scale_pixel_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scale_pixel_scheduler                                       |
// | Walks destination pixels in raster order, issues one source-sample   |
// | request per pixel to the scale pixel generator and pulses done once  |
// | the generator pipeline has drained.                                   |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module scale_pixel_scheduler
  import pkg_scalePixelScheduler::*;
#(
  parameter int unsigned FIXED        = C_FIXED,
  parameter int unsigned COORD_W      = C_COORD_W,
  parameter int unsigned DRAIN_CYCLES = C_DRAIN_CYCLES
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [COORD_W-1:0]       cfg_src_w,
  input  logic [COORD_W-1:0]       cfg_src_h,
  input  logic [COORD_W-1:0]       cfg_dst_w,
  input  logic [COORD_W-1:0]       cfg_dst_h,
  input  logic [COORD_W+FIXED-1:0] cfg_step_x,
  input  logic [COORD_W+FIXED-1:0] cfg_step_y,
  input  logic                     abort,
  input  logic                     spg_ready,
  output logic                     spg_start,
  output logic [COORD_W-1:0]       spg_sx,
  output logic [COORD_W-1:0]       spg_sy,
  output logic [FIXED-1:0]         spg_fx,
  output logic [FIXED-1:0]         spg_fy,
  output logic [COORD_W-1:0]       spg_dx,
  output logic [COORD_W-1:0]       spg_dy,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned    C_CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_DRAIN_LOAD = C_CNT_W'(DRAIN_CYCLES - 1);

  STATES_t            r_state;
  STATES_t            w_state_next;
  CFG_t               r_cfg;
  logic [C_CNT_W-1:0] r_drain_cnt;
  logic               r_zero_done;

  logic               w_cfg_hs;
  logic               w_cfg_zero;
  logic               w_drain_end;
  logic               w_last_pix;
  logic               w_x_last;
  logic               w_y_last;
  logic [COORD_W-1:0] w_src_w_eff;
  logic [COORD_W-1:0] w_src_h_eff;

  assign w_cfg_hs   = cfg_valid && cfg_ready;
  assign w_cfg_zero = (cfg_dst_w == '0) || (cfg_dst_h == '0);
  assign w_last_pix = spg_start && w_x_last && w_y_last;

  // At the handshake the clamp must already use the incoming source size.
  assign w_src_w_eff = w_cfg_hs ? cfg_src_w : r_cfg.src_w;
  assign w_src_h_eff = w_cfg_hs ? cfg_src_h : r_cfg.src_h;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_Idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_Idle: begin
        if (w_cfg_hs && !w_cfg_zero) begin
          w_state_next = S_Issue;
        end
      end
      S_Issue: begin
        if (abort) begin
          w_state_next = S_Idle;
        end else if (w_last_pix) begin
          w_state_next = S_Drain;
        end
      end
      S_Drain: begin
        if (abort || (r_drain_cnt == '0)) begin
          w_state_next = S_Idle;
        end
      end
      default: w_state_next = S_Idle;
    endcase
  end

  // Handshake, status and done outputs.
  always_comb begin
    cfg_ready   = (r_state == S_Idle);
    busy        = (r_state != S_Idle);
    spg_start   = (r_state == S_Issue) && spg_ready && !abort;
    w_drain_end = (r_state == S_Drain) && (r_drain_cnt == '0) && !abort;
    done        = w_drain_end || r_zero_done;
  end

  // Latch the job configuration; an empty destination completes immediately.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cfg       <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_cfg_hs && w_cfg_zero;
      if (w_cfg_hs) begin
        r_cfg.src_w  <= cfg_src_w;
        r_cfg.src_h  <= cfg_src_h;
        r_cfg.dst_w  <= cfg_dst_w;
        r_cfg.dst_h  <= cfg_dst_h;
        r_cfg.step_x <= cfg_step_x;
        r_cfg.step_y <= cfg_step_y;
      end
    end
  end

  // Drain counter covers the generator's read and compute latency after the last start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drain_cnt <= '0;
    end else if (w_last_pix) begin
      r_drain_cnt <= C_DRAIN_LOAD;
    end else if ((r_state == S_Drain) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  scale_axis_accumulator #(
    .FIXED   (FIXED),
    .COORD_W (COORD_W)
  ) u_axis_x (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (w_cfg_hs),
    .advance  (spg_start && !w_x_last),
    .wrap     (spg_start && w_x_last),
    .step     (r_cfg.step_x),
    .src      (w_src_w_eff),
    .last_idx (r_cfg.dst_w - COORD_W'(1)),
    .idx      (spg_dx),
    .is_last  (w_x_last),
    .pos_int  (spg_sx),
    .pos_frac (spg_fx)
  );

  scale_axis_accumulator #(
    .FIXED   (FIXED),
    .COORD_W (COORD_W)
  ) u_axis_y (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (w_cfg_hs),
    .advance  (spg_start && w_x_last),
    .wrap     (1'b0),
    .step     (r_cfg.step_y),
    .src      (w_src_h_eff),
    .last_idx (r_cfg.dst_h - COORD_W'(1)),
    .idx      (spg_dy),
    .is_last  (w_y_last),
    .pos_int  (spg_sy),
    .pos_frac (spg_fy)
  );

endmodule
`default_nettype wire
